serial_rx_32bits: RTL and testbench
===================================

Name: serial_rx_32bits

Overview:
- Bit-serial frame receiver: the receiving end of the team's serial word link.
- Deserializes framed words (start bit, DATA_WIDTH data bits LSB first, optional even parity bit, stop bit) into a parallel word.
- Presents the word through a valid/ready holding register.
- Sits between the serial pin logic and the top-level datapath/bus side.

Parameters:
DATA_WIDTH, 32, data bits per frame (2..32)
PARITY_EN, 1, 1 = even parity bit expected after data; 0 = no parity bit

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
rx_en  input  1  bit strobe; rx_in is sampled only on edges where rx_en=1
rx_in  input  1  serial line, idle high
data_out  output  DATA_WIDTH  received word, stable while data_valid=1
data_valid  output  1  holding register holds an unread word
data_ready  input  1  consumer accepts word when data_valid&data_ready
parity_err  output  1  parity mismatch flag for the word in data_out, valid with data_valid
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  sticky: completed word dropped because holding register full
overrun_clr  input  1  clears overrun
busy  output  1  1 whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset forces state=IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, bit counter=0, shift register=0, parity accumulator=0.
- Reset mid-frame discards the partial word; no flag is raised.
- No action is taken on edges with rx_en=0; the FSM holds and the data_valid/overrun logic still runs.
- FSM states and transitions (all transitions on rx_en=1 edges):
  - IDLE: rx_in=0 -> DATA; clear counter, shift register and accumulator. rx_in=1 -> stay.
  - DATA: shift right with rx_in into the MSB (LSB-first ordering); accumulator ^= rx_in; counter++. When counter reaches DATA_WIDTH-1 at the strobe (last bit): go to PARITY if PARITY_EN, else STOP.
  - PARITY: perr = rx_in ^ accumulator (even parity: the transmitted bit equals the XOR of the data bits) -> STOP.
  - STOP, rx_in=1: deliver the word -> IDLE.
  - STOP, rx_in=0: frame_err=1 for exactly the next cycle; word dropped; no data_valid change -> IDLE.
- Word delivery, decided on the stop-bit edge:
  - Load when data_valid=0, or when data_valid=1 and data_ready=1 on the same edge (back-to-back accept-and-load).
  - On load: data_out=shift register, parity_err=perr (0 if PARITY_EN=0), data_valid=1.
  - Otherwise: word dropped and overrun=1; data_out and parity_err are unchanged.
- data_valid clears on an edge with data_valid&data_ready when no load occurs on that edge.
- Latency: data_valid rises on the stop-bit sampling edge, i.e. visible in the cycle after the stop strobe.
- Minimum frame length is DATA_WIDTH+2+PARITY_EN strobes.
- overrun:
  - Set beats clear when both occur on the same edge.
  - overrun_clr alone clears it.
  - Cleared only by overrun_clr or reset.
- busy is combinational from state.
- frame_err is 0 on every cycle other than the one following a bad stop.
- A start bit accepted on the edge right after returning to IDLE is legal, so frames may be back-to-back.

Test Plan:
- Reset, idle line rx_in=1 with rx_en=1 for 10 cycles -> busy=0, data_valid=0, all flags 0.
- Frame 0xA5A50F0F, parity bit 0, stop 1, rx_en every cycle -> data_valid=1 one cycle after the stop strobe; data_out=0xA5A50F0F; parity_err=0. Pulse data_ready=1 -> data_valid=0 next cycle.
- Frame 0x00000001 with parity bit 0 (wrong) -> data_out=0x00000001, parity_err=1.
- Frame 0x12345678 with stop bit 0 -> frame_err high for exactly one cycle; data_valid stays 0; next start bit is accepted.
- Two back-to-back frames 0x11111111 and 0x22222222, data_ready=0 throughout -> data_out stays 0x11111111 and overrun=1. Assert overrun_clr -> overrun=0. Repeat with data_ready=1 held on the second stop edge -> data_out=0x22222222, data_valid stays 1, overrun stays 0.
- rx_en strobing every 4th cycle; assert reset after 10 data bits, then send a full frame 0xDEADBEEF -> after reset busy=0 and data_valid=0; the later frame yields data_out=0xDEADBEEF with parity_err=0 when parity bit 0 is sent.

Source files
------------

// File: rtl/serial_rx_32bits.sv
// serial_rx_32bits: framed bit-serial receiver (start, LSB-first data, optional even parity, stop)
// feeding a valid/ready holding register with frame-error pulse and sticky overrun.
module serial_rx_32bits #(
  parameter int DATA_WIDTH = 32,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_en,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, dout_q, dout_d;
  logic acc_q, acc_d, perr_q, perr_d, perr_out_q, perr_out_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic start, shift, par, stop_ok, stop_bad, ld;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (rx_en) begin
      case (state_q)
        IDLE:    state_d = rx_in ? IDLE : DATA;
        DATA:    state_d = (cnt_q != LAST) ? DATA : (PARITY_EN ? PARITY : STOP);
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    busy     = state_q != IDLE;
    start    = rx_en && state_q == IDLE && !rx_in;
    shift    = rx_en && state_q == DATA;
    par      = rx_en && state_q == PARITY;
    stop_ok  = rx_en && state_q == STOP && rx_in;
    stop_bad = rx_en && state_q == STOP && !rx_in;
    ld       = stop_ok && (!valid_q || data_ready);
  end
  // a completed word that cannot be loaded is dropped and flagged; setting wins over clearing
  always_comb begin
    cnt_d      = start ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    sh_d       = start ? '0 : shift ? {rx_in, sh_q[DATA_WIDTH-1:1]} : sh_q;
    acc_d      = start ? 1'b0 : shift ? acc_q ^ rx_in : acc_q;
    perr_d     = start ? 1'b0 : par ? rx_in ^ acc_q : perr_q;
    dout_d     = ld ? sh_q : dout_q;
    perr_out_d = ld ? perr_q : perr_out_q;
    valid_d    = ld || (valid_q && !data_ready);
    ferr_d     = stop_bad;
    ovr_d      = (stop_ok && !ld) || (ovr_q && !overrun_clr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      sh_q       <= '0;
      acc_q      <= 1'b0;
      perr_q     <= 1'b0;
      dout_q     <= '0;
      perr_out_q <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      perr_q     <= perr_d;
      dout_q     <= dout_d;
      perr_out_q <= perr_out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_serial_rx_32bits.sv
// tb_serial_rx_32bits: directed plus randomized frames checked against a frame-level model
// of the holding register, parity and overrun behaviour.
module tb_serial_rx_32bits;
  logic clk = 1'b0;
  logic reset, rx_en, rx_in, data_ready, overrun_clr;
  logic [31:0] data_out;
  logic data_valid, parity_err, frame_err, overrun, busy;
  int checks = 0;
  int errors = 0;
  logic m_valid, m_perr, m_ovr;
  logic [31:0] m_data;

  serial_rx_32bits dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rx_in(rx_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic en, input logic b, input logic rdy, input logic clr);
    @(negedge clk);
    rx_en = en; rx_in = b; data_ready = rdy; overrun_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    for (int g = 0; g < gap; g++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, {31'b0, data_valid}, {31'b0, m_valid});
    chk({tag, "_data"}, data_out, m_data);
    chk({tag, "_perr"}, {31'b0, parity_err}, {31'b0, m_perr});
    chk({tag, "_ovr"}, {31'b0, overrun}, {31'b0, m_ovr});
  endtask

  task automatic send_frame(input logic [31:0] w, input logic p, input logic stop,
                            input int gap, input logic rdy, input logic clr);
    logic ld;
    strobe(1'b0, gap);
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_ferr", {31'b0, frame_err}, 32'd0);
    for (int i = 0; i < 32; i++) strobe(w[i], gap);
    strobe(p, gap);
    chk("pre_stop_valid", {31'b0, data_valid}, {31'b0, m_valid});
    for (int g = 0; g < gap; g++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, stop, rdy, clr);
    ld = stop && (!m_valid || rdy);
    if (ld) begin
      m_valid = 1'b1; m_data = w; m_perr = p ^ (^w);
    end else if (m_valid && rdy) m_valid = 1'b0;
    if (stop && !ld) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    check_state("stop");
    chk("stop_ferr", {31'b0, frame_err}, {31'b0, !stop});
    chk("stop_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic accept();
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    m_valid = 1'b0;
    check_state("accept");
  endtask

  task automatic clear_ovr();
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    m_ovr = 1'b0;
    check_state("ovr_clr");
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1; rx_en = 1'b0; rx_in = 1'b1; data_ready = 1'b0; overrun_clr = 1'b0;
    m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0; m_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check_state("reset");
    chk("reset_busy", {31'b0, busy}, 32'd0);
    repeat (10) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check_state("idle");
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_ferr", {31'b0, frame_err}, 32'd0);

    send_frame(32'hA5A50F0F, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    accept();
    send_frame(32'h00000001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("bad_parity", {31'b0, parity_err}, 32'd1);
    accept();
    send_frame(32'h12345678, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(32'h0000FFFF, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    accept();

    send_frame(32'h11111111, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    send_frame(32'h22222222, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("overrun_data", data_out, 32'h11111111);
    clear_ovr();
    accept();
    send_frame(32'h11111111, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    send_frame(32'h22222222, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    chk("b2b_data", data_out, 32'h22222222);
    send_frame(32'h44444444, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    chk("set_beats_clr", {31'b0, overrun}, 32'd1);
    clear_ovr();
    accept();

    w = 32'hDEADBEEF;
    strobe(1'b0, 3);
    for (int i = 0; i < 10; i++) strobe(w[i], 3);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    @(negedge clk) reset = 1'b1;
    #1;
    m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0; m_data = 32'h0;
    check_state("mid_reset");
    chk("mid_reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clk) reset = 1'b0;
    send_frame(32'hDEADBEEF, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    accept();

    for (int n = 0; n < 12; n++) begin
      logic p, stop, rdy, clr;
      w    = $urandom;
      p    = (^w) ^ ($urandom_range(0, 3) == 0);
      stop = $urandom_range(0, 4) != 0;
      rdy  = 1'($urandom_range(0, 1));
      clr  = $urandom_range(0, 3) == 0;
      send_frame(w, p, stop, $urandom_range(0, 3), rdy, clr);
      if ($urandom_range(0, 2) == 0) accept();
      if ($urandom_range(0, 3) == 0) clear_ovr();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
